// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : hazard_controller
// Brief   : Pipeline sequencing controller for the five-stage RISC-V core.
//           Resolves load-use stalls, taken-branch flushes and data-memory
//           waits, and counts cycles in which the PC was held.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_controller #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES      = 1,
   parameter int CNT_W             = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_ex_memread,
   input  logic [4:0]       id_ex_rd,
   input  logic             ex_branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             perf_clear,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             mem_stall,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } state_t;

   // Counter reload values: the cycle spent in RUN already counts as the first
   localparam logic [3:0] LOAD_CNT_INIT  = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);
   localparam bit         LOAD_MULTI     = (LOAD_STALL_CYCLES > 1);
   localparam bit         FLUSH_MULTI    = (FLUSH_CYCLES > 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic lu;
   logic mw;

   // x0 is hardwired to zero, so a load targeting it can never create a hazard
   assign lu = id_ex_memread & (id_ex_rd != 5'd0) &
               ((id_uses_rs1 & (id_rs1 == id_ex_rd)) |
                (id_uses_rs2 & (id_rs2 == id_ex_rd)));
   assign mw = dmem_req & ~dmem_ready;

   // Next-state and control outputs; memory wait outranks branch outranks load-use
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      mem_stall    = 1'b0;

      if (state_q == ST_MEM_WAIT) begin
         // Whole pipe frozen; EX cannot resolve a branch, so it is ignored here
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         mem_stall   = 1'b1;
         cnt_d       = 4'd0;
         if (dmem_ready) begin
            state_d = ST_RUN;
         end
      end else if (mw) begin
         // Pending stall/flush counts are dropped; RUN re-evaluates the held inputs
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         mem_stall   = 1'b1;
         state_d     = ST_MEM_WAIT;
         cnt_d       = 4'd0;
      end else if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         if (FLUSH_MULTI) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_CNT_INIT;
         end else begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end
      end else if (state_q == ST_FLUSH) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (state_q == ST_LOAD_STALL) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (lu) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
         if (LOAD_MULTI) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = LOAD_CNT_INIT;
         end
      end

      // Reset forces the safe pattern immediately, independent of the clock
      if (!reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         id_ex_bubble = 1'b1;
         if_id_flush  = 1'b1;
         mem_stall    = 1'b0;
      end
   end

   // Stall-cycle counter: clear wins over a saturating increment
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (perf_clear) begin
         stall_cycles_d = '0;
      end else if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   // State, countdown and performance counter registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_RUN;
         cnt_q          <= 4'd0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire
